lb_reg_slave: RTL
=================

# lb_reg_slave

Parametrised localbus register-bank slave for the Marble test family. It sits behind `mem_gateway` on the `addr`/`control_strobe`/`control_rd`/`data_out`/`data_in` localbus and holds a configurable set of read/write registers, read-only status inputs, sticky event flags, a free-running cycle counter and a `stop_sim` control bit. Read data returns with an exact, parametrised latency `n_lat` so it matches the gateway's `n_lat`, and a read-valid strobe is generated. It is the reusable, generalised successor to the ad-hoc register decode in the board-level localbus slave.

## Interface
- `aw`, 24: localbus address width.
- `page`, 0: required value of `addr[aw-1:8]`; other pages are not decoded.
- `n_rw`, 8: number of read/write registers, 1..16.
- `n_ro`, 4: number of read-only status words, 1..16.
- `n_ev`, 8: number of sticky event inputs, 1..32.
- `n_lat`, 8: read latency in cycles, 2..15.
- `id_word`, 32'h6c627231: constant returned at address 0x23.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `addr` in `aw`: localbus address.
- `control_strobe` in 1: bus cycle qualifier.
- `control_rd` in 1: 1 = read, 0 = write; sampled with `control_strobe`.
- `data_out` in 32: write data from master.
- `data_in` out 32: read data to master.
- `rd_valid` out 1: `data_in` valid, one cycle per read.
- `ro_in` in 32*`n_ro`: status words, word k at bits [32k+31:32k].
- `ev_in` in `n_ev`: event pulses/levels, sampled every cycle.
- `rw_out` out 32*`n_rw`: register contents, same packing as `ro_in`.
- `wr_stb` out `n_rw`: one-cycle pulse per register written.
- `stop_sim` out 1: simulation-stop request.

## Operation
- Hit = `control_strobe` & (`addr[aw-1:8]` == `page`). Write = hit & ~`control_rd`; read = hit & `control_rd`.
- Address map (`addr[7:0]`): 0x00+k RW reg k (k < `n_rw`); 0x10+k RO word k (k < `n_ro`); 0x20 sticky events (bit i = `ev_in[i]`, upper bits 0); 0x21 control, bit 0 = `stop_sim`; 0x22 cycle counter; 0x23 `id_word`. All other offsets: writes ignored, reads return 0.
- RW write: register k <= `data_out` at the next edge; `wr_stb[k]` high for that same cycle only.
- Sticky: bit i set on any cycle `ev_in[i]`=1; write to 0x20 clears bits where `data_out` is 1 (W1C). Set and clear in the same cycle: set wins.
- 0x21 write: `stop_sim` <= `data_out[0]`. 0x22 and 0x23 are read-only; writes ignored.
- Cycle counter: 32-bit, +1 every cycle, wraps 0xFFFFFFFF -> 0, not affected by bus traffic.
- Read: mux selected on the strobe cycle and registered (stage 1), then delayed through a shift pipeline carrying data plus valid bit. Sampled value is the register state before any same-cycle write or event.
- Misses (wrong page) produce no `rd_valid` and no write effect.

## Timing
- Read issued at cycle T: `data_in` and `rd_valid`=1 at cycle T+`n_lat`; `rd_valid` low otherwise. `data_in` holds its last value when `rd_valid` is low.
- Fully pipelined: a read every cycle gives `rd_valid` every cycle, in order, no bubbles. Interleaved writes do not disturb in-flight reads.
- Write at T: `rw_out`, sticky clear, `stop_sim` update visible at T+1.
- Reset: `rw_out`=0, `wr_stb`=0, sticky=0, `stop_sim`=0, counter=0, `data_in`=0, `rd_valid`=0, all pipeline valid bits cleared. Reads in flight at reset are dropped (no `rd_valid` after reset). Counter reads 0 in the first cycle after reset deassertion.
- Events asserted while `rst`=1 are not captured.

## Test plan
- Reset, then write 0x12345678 to 0x03, read 0x03 -> `wr_stb[3]` pulses one cycle, `rw_out` word 3 = 0x12345678, `data_in`=0x12345678 with `rd_valid` exactly 8 cycles after read strobe.
- Back-to-back reads of 0x10, 0x11, 0x23, 0x40 with `ro_in` words 0xA0, 0xA1 -> four consecutive `rd_valid` cycles returning 0xA0, 0xA1, 0x6c627231, 0x0.
- Pulse `ev_in[2]`, read 0x20 -> 0x4; write 0x4 to 0x20 while `ev_in[2]`=1 -> still 0x4; repeat with `ev_in` low -> reads 0x0.
- Read 0x22 twice, 5 cycles apart -> difference 5; force counter near 0xFFFFFFFF -> wraps to 0.
- Write 1 to 0x21 -> `stop_sim`=1 next cycle; write at `addr` page 1 with `page`=0 -> no effect, no `rd_valid` on read.
- Issue read, assert `rst` at T+3 -> no `rd_valid` at T+8, all outputs at reset values.

Source files
------------

// File: rtl/lb_reg_slave.sv
// Localbus register-bank slave: RW registers, RO status words, sticky
// event flags, free-running cycle counter, stop_sim control and ID word.
// Reads return through a fixed-latency pipeline with a valid strobe.
module lb_reg_slave #(
  parameter int          aw      = 24,
  parameter int          page    = 0,
  parameter int          n_rw    = 8,
  parameter int          n_ro    = 4,
  parameter int          n_ev    = 8,
  parameter int          n_lat   = 8,
  parameter logic [31:0] id_word = 32'h6c627231
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [aw-1:0]        addr,
  input  logic                 control_strobe,
  input  logic                 control_rd,
  input  logic [31:0]          data_out,
  output logic [31:0]          data_in,
  output logic                 rd_valid,
  input  logic [32*n_ro-1:0]   ro_in,
  input  logic [n_ev-1:0]      ev_in,
  output logic [32*n_rw-1:0]   rw_out,
  output logic [n_rw-1:0]      wr_stb,
  output logic                 stop_sim
);

  localparam logic [aw-9:0] PAGE_V = (aw-8)'(page);

  logic                 hit, wr, rd;
  logic [7:0]           off;
  logic [n_rw-1:0][31:0] rw_q;
  logic [n_ev-1:0]      sticky, clr;
  logic [31:0]          cnt;
  logic [31:0]          rd_mux;
  logic [n_lat:1]       vld_pipe;
  logic [31:0]          dat_pipe [1:n_lat];

  assign hit    = control_strobe && (addr[aw-1:8] == PAGE_V);
  assign wr     = hit && !control_rd;
  assign rd     = hit && control_rd;
  assign off    = addr[7:0];
  assign rw_out = rw_q;
  assign clr    = (wr && off == 8'h20) ? data_out[n_ev-1:0] : '0;

  // Read mux: selects current (pre-write, pre-event) state by offset
  always_comb begin
    rd_mux = '0;
    if (off[7:4] == 4'h0) begin
      for (int k = 0; k < n_rw; k++)
        if (off[3:0] == 4'(k)) rd_mux = rw_q[k];
    end else if (off[7:4] == 4'h1) begin
      for (int k = 0; k < n_ro; k++)
        if (off[3:0] == 4'(k)) rd_mux = ro_in[32*k +: 32];
    end else begin
      case (off)
        8'h20:   rd_mux = 32'(sticky);
        8'h21:   rd_mux = {31'b0, stop_sim};
        8'h22:   rd_mux = cnt;
        8'h23:   rd_mux = id_word;
        default: rd_mux = '0;
      endcase
    end
  end

  // RW registers, per-register write strobes and the stop_sim bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q     <= '0;
      wr_stb   <= '0;
      stop_sim <= 1'b0;
    end else begin
      wr_stb <= '0;
      for (int k = 0; k < n_rw; k++) begin
        if (wr && off == 8'(k)) begin
          rw_q[k]   <= data_out;
          wr_stb[k] <= 1'b1;
        end
      end
      if (wr && off == 8'h21) stop_sim <= data_out[0];
    end
  end

  // Sticky flags: W1C clear, a same-cycle event set overrides the clear
  always_ff @(posedge clk) begin
    if (rst) sticky <= '0;
    else     sticky <= (sticky & ~clr) | ev_in;
  end

  // Free-running cycle counter, wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 32'd1;
  end

  // Read pipeline: stage 1 registers the mux, later stages shift data+valid;
  // the last data stage only loads on valid so data_in holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int k = 1; k <= n_lat; k++) dat_pipe[k] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[n_lat-1:1], rd};
      dat_pipe[1] <= rd_mux;
      for (int k = 2; k < n_lat; k++) dat_pipe[k] <= dat_pipe[k-1];
      if (vld_pipe[n_lat-1]) dat_pipe[n_lat] <= dat_pipe[n_lat-1];
    end
  end

  assign data_in  = dat_pipe[n_lat];
  assign rd_valid = vld_pipe[n_lat];

endmodule
